io_input_conditioner: RTL

- Sits between the board switch/push-button pins and the pipeline core's i_io_sw / i_io_btn input buffer.
- Synchronizes every raw input into the core clock domain and debounces each bit.
- Converts buttons to active-high pressed levels and adds one-cycle press pulses plus sticky press flags the core clears by write-1-to-clear.
- Outputs are 32-bit, zero-extended, ready to drive i_io_sw / i_io_btn directly.

---
 rtl/io_pkg.sv | 18 +
 rtl/io_debounce_bit.sv | 54 +++++
 rtl/io_input_conditioner.sv | 84 ++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants and helpers for the board I/O input conditioning slice.
package io_pkg;

  localparam int IO_WORD_W      = 32;
  localparam int BTN_STICKY_LSB = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One raw input bit: flop-chain synchronizer, optional inversion, then a
// hold-time debouncer that only accepts a new value after it stays put.
module io_debounce_bit
  import io_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_VAL       = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   syncLevel;

  assign syncLevel = sync_q[SYNC_STAGES-1] ^ INVERT;

  // Any sample that agrees with the accepted level restarts the hold count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (syncLevel != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = syncLevel;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounced switch/button words for the core's i_io_sw / i_io_btn buffers,
// with press pulses and write-1-to-clear sticky press flags.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int N_SW            = 18,
  parameter int N_BTN           = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_SW-1:0]      i_sw_raw,
  input  logic [N_BTN-1:0]     i_btn_raw,
  input  logic [N_BTN-1:0]     i_btn_clr,
  output logic [IO_WORD_W-1:0] o_io_sw,
  output logic [IO_WORD_W-1:0] o_io_btn,
  output logic [N_BTN-1:0]     o_btn_press
);

  logic [N_SW-1:0]  swLevel;
  logic [N_BTN-1:0] btnLevel;
  logic [N_BTN-1:0] btnPrev_q;
  logic [N_BTN-1:0] sticky_q, sticky_d;
  logic [N_BTN-1:0] btnPress;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    io_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0),
      .INVERT         (1'b0)
    ) u_bit (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_sw_raw[i]),
      .o_level(swLevel[i])
    );
  end

  // Buttons reset to their released pin level and come out active-high.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    io_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (BTN_ACTIVE_LOW),
      .INVERT         (BTN_ACTIVE_LOW)
    ) u_bit (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_btn_raw[i]),
      .o_level(btnLevel[i])
    );
  end

  assign btnPress = btnLevel & ~btnPrev_q;

  // A new press beats a same-cycle clear so no press is ever lost.
  always_comb begin
    sticky_d = btnPress | (sticky_q & ~i_btn_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btnPrev_q <= '0;
      sticky_q  <= '0;
    end else begin
      btnPrev_q <= btnLevel;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    o_io_sw                             = '0;
    o_io_sw[N_SW-1:0]                   = swLevel;
    o_io_btn                            = '0;
    o_io_btn[N_BTN-1:0]                 = btnLevel;
    o_io_btn[BTN_STICKY_LSB +: N_BTN]   = sticky_q;
  end

  assign o_btn_press = btnPress;

endmodule
